relu_backward_stream_layer: RTL

Streaming, parametrised ReLU / leaky-ReLU backward layer for the training datapath. Each beat carries WIDTH fp32 lanes of the forward-pass activation and the upstream gradient. Per lane, it passes the gradient where the activation was positive. Otherwise it forces the gradient to zero, or scales it by a power-of-two negative slope. The block adds a two-stage valid/ready pipeline, id tagging aligned to data, and a per-beat count of gated lanes, and sits between the loss/upper-layer gradient stream and the preceding layer's backward unit.

---
 rtl/relu_pkg.sv | 26 ++
 rtl/relu_backward_lane.sv | 26 ++
 rtl/relu_backward_stream_layer.sv | 98 +++++++++
 3 files changed

// File: rtl/relu_pkg.sv
// Shared fp32 helpers for the ReLU backward datapath: field positions and
// the sign/zero-aware power-of-two down-scale used by the leaky slope.
package relu_pkg;

  typedef logic [31:0] fp32_t;

  localparam int         FP_EXP_MSB = 30;
  localparam int         FP_EXP_LSB = 23;
  localparam logic [7:0] FP_EXP_INF = 8'hFF;

  // Strictly positive: sign clear and not +0.0. +Inf and +NaN count as positive.
  function automatic logic fp_is_positive(input fp32_t x);
    return !x[31] && (x[FP_EXP_MSB:0] != 31'd0);
  endfunction

  // x * 2^-shift by exponent subtraction; the compare guards the subtraction
  // so it never wraps, and results that would go subnormal flush to signed zero.
  function automatic fp32_t fp_scale_pow2(input fp32_t x, input logic [4:0] shift);
    logic [7:0] e;
    e = x[FP_EXP_MSB:FP_EXP_LSB];
    if (e == FP_EXP_INF) return x;
    if (e <= {3'b000, shift}) return {x[31], 31'd0};
    return {x[31], e - {3'b000, shift}, x[FP_EXP_LSB-1:0]};
  endfunction

endpackage

// File: rtl/relu_backward_lane.sv
// One combinational lane of the ReLU / leaky-ReLU backward pass: pass the
// gradient where the forward activation was positive, otherwise gate it.
module relu_backward_lane
  import relu_pkg::*;
#(
  parameter int LEAKY       = 0,
  parameter int SLOPE_SHIFT = 3
) (
  input  logic [31:0] fwd,
  input  logic [31:0] grad,
  output logic [31:0] out,
  output logic        gated
);

  localparam logic [4:0] SHIFT = 5'(SLOPE_SHIFT);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    gated = !fp_is_positive(fwd);
    out   = grad;
    if (gated) begin
      out = (LEAKY != 0) ? fp_scale_pow2(grad, SHIFT) : 32'h0000_0000;
    end
  end

endmodule

// File: rtl/relu_backward_stream_layer.sv
// Streaming ReLU backward layer: WIDTH lanes per beat, two valid/ready
// register stages, id tag and gated-lane count carried alongside the data.
module relu_backward_stream_layer
  import relu_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LEAKY       = 0,
  parameter int SLOPE_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 id,
  input  logic [32*WIDTH-1:0]        fwd_vec,
  input  logic [32*WIDTH-1:0]        grad_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 id_out,
  output logic [32*WIDTH-1:0]        out_vec,
  output logic [$clog2(WIDTH+1)-1:0] gate_cnt
);

  localparam int CNT_W = $clog2(WIDTH+1);

  logic [32*WIDTH-1:0] lane_out;
  logic [WIDTH-1:0]    lane_gated;
  logic [CNT_W-1:0]    lane_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    relu_backward_lane #(
      .LEAKY       (LEAKY),
      .SLOPE_SHIFT (SLOPE_SHIFT)
    ) u_lane (
      .fwd   (fwd_vec[32*i +: 32]),
      .grad  (grad_vec[32*i +: 32]),
      .out   (lane_out[32*i +: 32]),
      .gated (lane_gated[i])
    );
  end

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_cnt = lane_cnt + CNT_W'(lane_gated[i]);
    end
  end

  logic                s1_valid;
  logic [7:0]          s1_id;
  logic [32*WIDTH-1:0] s1_vec;
  logic [CNT_W-1:0]    s1_cnt;
  logic                s2_valid;
  logic                s1_adv;
  logic                s2_adv;

  // A stage may load whenever it is empty or its contents leave this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // NOTE: datapath registers are reset too, so out_vec/id_out/gate_cnt read 0 while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_vec   <= '0;
      s1_cnt   <= '0;
    end else if (s1_adv) begin
      // NOTE: non-blocking so S2 below samples the pre-edge S1 contents.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_id  <= id;
        s1_vec <= lane_out;
        s1_cnt <= lane_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      id_out   <= '0;
      out_vec  <= '0;
      gate_cnt <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        id_out   <= s1_id;
        out_vec  <= s1_vec;
        gate_cnt <= s1_cnt;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
